// File: rtl/ransac_ram_arbiter_if.sv
// Avalon-MM style requester bundle for one port of the RANSAC data-RAM arbiter.
// The master drives the request; the slave (arbiter) returns waitrequest and read data.
interface ransac_ram_arbiter_if #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 32
);
    logic [AW-1:0]   address;
    logic [DW/8-1:0] byteenable;
    logic            read;
    logic            write;
    logic [DW-1:0]   writedata;
    logic            waitrequest;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/ransac_ram_arbiter.sv
// Two-port arbiter in front of a single-port data RAM (port A = Nios II, port B = RANSAC accel).
// Define RAM_ARB_BURST_EN for B-priority with bounded bursts; default is round-robin.
module ransac_ram_arbiter #(
    parameter int unsigned AW        = 12,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    ransac_ram_arbiter_if.slave a,
    ransac_ram_arbiter_if.slave b,
    output logic [AW-1:0]       ram_address,
    output logic [DW/8-1:0]     ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DW-1:0]       ram_writedata,
    output logic                ram_clken,
    input  logic [DW-1:0]       ram_readdata
);

    if (MAX_BURST == 0) begin : g_bad_max_burst
        $error("MAX_BURST must be at least 1");
    end

    logic w_req_a;
    logic w_req_b;
    logic w_gnt_a;
    logic w_gnt_b;
    logic w_gnt;
    logic w_rd_gnt;
    logic w_b_prio;

    logic [AW-1:0]   r_addr;
    logic [DW/8-1:0] r_be;
    logic [DW-1:0]   r_wdata;
    logic            r_rd_pend;
    logic            r_rd_src;

    assign w_req_a = a.read | a.write;
    assign w_req_b = b.read | b.write;

`ifdef RAM_ARB_BURST_EN
    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0] r_burst_cnt;

    assign w_b_prio = (r_burst_cnt < CW'(MAX_BURST));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_burst_cnt <= '0;
        end else if (w_gnt_a || !w_req_a) begin
            r_burst_cnt <= '0;
        end else if (w_gnt_b && (r_burst_cnt < CW'(MAX_BURST))) begin
            r_burst_cnt <= r_burst_cnt + CW'(1);
        end
    end
`else
    logic r_last_gnt;  // 0 = A, 1 = B

    assign w_b_prio = ~r_last_gnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_gnt <= 1'b0;
        end else if (w_gnt) begin
            r_last_gnt <= w_gnt_b;
        end
    end
`endif

    // No grants while in reset so the RAM never sees a strobe.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (reset_n) begin
            if (w_req_a && w_req_b) begin
                w_gnt_b = w_b_prio;
                w_gnt_a = ~w_b_prio;
            end else begin
                w_gnt_a = w_req_a;
                w_gnt_b = w_req_b;
            end
        end
    end

    assign w_gnt    = w_gnt_a | w_gnt_b;
    assign w_rd_gnt = (w_gnt_a & ~a.write) | (w_gnt_b & ~b.write);

    assign ram_address    = w_gnt_b ? b.address    : (w_gnt_a ? a.address    : r_addr);
    assign ram_byteenable = w_gnt_b ? b.byteenable : (w_gnt_a ? a.byteenable : r_be);
    assign ram_writedata  = w_gnt_b ? b.writedata  : (w_gnt_a ? a.writedata  : r_wdata);
    assign ram_chipselect = w_gnt;
    assign ram_write      = (w_gnt_a & a.write) | (w_gnt_b & b.write);
    assign ram_clken      = reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_rd_pend <= 1'b0;
            r_rd_src  <= 1'b0;
        end else begin
            if (w_gnt) begin
                r_addr  <= ram_address;
                r_be    <= ram_byteenable;
                r_wdata <= ram_writedata;
            end
            r_rd_pend <= w_rd_gnt;
            if (w_rd_gnt) begin
                r_rd_src <= w_gnt_b;
            end
        end
    end

    assign a.waitrequest   = w_req_a & ~w_gnt_a;
    assign b.waitrequest   = w_req_b & ~w_gnt_b;
    assign a.readdatavalid = r_rd_pend & ~r_rd_src;
    assign b.readdatavalid = r_rd_pend & r_rd_src;
    assign a.readdata      = ram_readdata;
    assign b.readdata      = ram_readdata;

    a_rw_excl : assert property (@(posedge clk) disable iff (!reset_n) !(a.read && a.write));
    b_rw_excl : assert property (@(posedge clk) disable iff (!reset_n) !(b.read && b.write));
    gnt_onehot : assert property (@(posedge clk) disable iff (!reset_n) !(w_gnt_a && w_gnt_b));

endmodule

// File: tb/tb_ransac_ram_arbiter.sv
// Self-checking bench for ransac_ram_arbiter: vector table with expected grants, a scoreboard of
// expected read returns, and hand-written reset sequences. Works with or without RAM_ARB_BURST_EN.
module tb_ransac_ram_arbiter;

    typedef struct {
        logic        ar;
        logic        aw;
        logic [11:0] aa;
        logic [3:0]  abe;
        logic [31:0] ad;
        logic        br;
        logic        bw;
        logic [11:0] ba;
        logic [3:0]  bbe;
        logic [31:0] bd;
        int          gnt;  // 0 none, 1 A, 2 B
    } vec_t;

    typedef struct {
        logic        src;  // 0 A, 1 B
        logic [31:0] data;
    } rd_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic        ram_clken;
    logic [31:0] ram_readdata;

    logic [31:0] mem    [0:4095];
    logic [31:0] shadow [0:4095];
    logic [11:0] ram_addr_q;

    int          errors = 0;
    int          checks = 0;
    rd_t         sb[$];
    vec_t        vecs[$];
    logic [11:0] last_addr;
    logic        addr_known = 1'b0;

    always #5 clk = ~clk;

    ransac_ram_arbiter_if #(.AW(12), .DW(32)) a_if ();
    ransac_ram_arbiter_if #(.AW(12), .DW(32)) b_if ();

    ransac_ram_arbiter #(.AW(12), .DW(32), .MAX_BURST(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .a              (a_if),
        .b              (b_if),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata)
    );

    // Single-port RAM: registered address, unregistered q.
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            ram_addr_q <= ram_address;
            if (ram_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (ram_byteenable[i]) mem[ram_address][8*i +: 8] <= ram_writedata[8*i +: 8];
                end
            end
        end
    end
    assign ram_readdata = mem[ram_addr_q];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic vec_t mk(input logic ar, input logic aw, input logic [11:0] aa,
                                input logic [3:0] abe, input logic [31:0] ad,
                                input logic br, input logic bw, input logic [11:0] ba,
                                input logic [3:0] bbe, input logic [31:0] bd, input int gnt);
        vec_t v;
        v.ar = ar; v.aw = aw; v.aa = aa; v.abe = abe; v.ad = ad;
        v.br = br; v.bw = bw; v.ba = ba; v.bbe = bbe; v.bd = bd; v.gnt = gnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        a_if.read = v.ar; a_if.write = v.aw; a_if.address = v.aa;
        a_if.byteenable = v.abe; a_if.writedata = v.ad;
        b_if.read = v.br; b_if.write = v.bw; b_if.address = v.ba;
        b_if.byteenable = v.bbe; b_if.writedata = v.bd;
    endtask

    task automatic check_valids();
        rd_t r;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            check("a_readdatavalid", {31'b0, a_if.readdatavalid}, {31'b0, ~r.src});
            check("b_readdatavalid", {31'b0, b_if.readdatavalid}, {31'b0, r.src});
            check(r.src ? "b_readdata" : "a_readdata",
                  r.src ? b_if.readdata : a_if.readdata, r.data);
        end else begin
            check("a_readdatavalid idle", {31'b0, a_if.readdatavalid}, 32'd0);
            check("b_readdatavalid idle", {31'b0, b_if.readdatavalid}, 32'd0);
        end
    endtask

    // Expected effect of a grant on the RAM port, shadow memory and scoreboard.
    task automatic expect_grant(input logic src, input logic wr, input logic [11:0] addr,
                                input logic [3:0] be, input logic [31:0] data);
        rd_t r;
        check("ram_chipselect", {31'b0, ram_chipselect}, 32'd1);
        check("ram_address", {20'b0, ram_address}, {20'b0, addr});
        check("ram_byteenable", {28'b0, ram_byteenable}, {28'b0, be});
        check("ram_write", {31'b0, ram_write}, {31'b0, wr});
        if (wr) begin
            check("ram_writedata", ram_writedata, data);
            shadow[addr] = merge(shadow[addr], data, be);
        end else begin
            r.src = src;
            r.data = shadow[addr];
            sb.push_back(r);
        end
        last_addr  = addr;
        addr_known = 1'b1;
    endtask

    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        apply(v);
        @(negedge clk);
        check_valids();
        check("a_waitrequest", {31'b0, a_if.waitrequest}, {31'b0, (v.ar | v.aw) && v.gnt != 1});
        check("b_waitrequest", {31'b0, b_if.waitrequest}, {31'b0, (v.br | v.bw) && v.gnt != 2});
        if (v.gnt == 1) begin
            expect_grant(1'b0, v.aw, v.aa, v.abe, v.ad);
        end else if (v.gnt == 2) begin
            expect_grant(1'b1, v.bw, v.ba, v.bbe, v.bd);
        end else begin
            check("ram_chipselect idle", {31'b0, ram_chipselect}, 32'd0);
            check("ram_write idle", {31'b0, ram_write}, 32'd0);
            if (addr_known) check("ram_address hold", {20'b0, ram_address}, {20'b0, last_addr});
        end
    endtask

    initial begin
        vec_t idle;
        vec_t tie;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 32'h0;
            shadow[i] = 32'h0;
        end
        ram_addr_q = 12'h0;
        idle = mk(0, 0, 12'h000, 4'h0, 32'h0, 0, 0, 12'h000, 4'h0, 32'h0, 0);
        tie  = mk(1, 0, 12'h010, 4'hF, 32'h0, 1, 0, 12'hFFF, 4'hF, 32'h0, 0);

        // Reset held with an A read pending: nothing reaches the RAM.
        apply(mk(1, 0, 12'h000, 4'hF, 32'h0, 0, 0, 12'h000, 4'h0, 32'h0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst a_readdatavalid", {31'b0, a_if.readdatavalid}, 32'd0);
        check("rst ram_chipselect", {31'b0, ram_chipselect}, 32'd0);
        check("rst ram_write", {31'b0, ram_write}, 32'd0);
        check("rst ram_clken", {31'b0, ram_clken}, 32'd0);
        reset_n = 1'b1;
        #1;
        check("rel ram_clken", {31'b0, ram_clken}, 32'd1);
        check("rel a_waitrequest", {31'b0, a_if.waitrequest}, 32'd0);
        expect_grant(1'b0, 1'b0, 12'h000, 4'hF, 32'h0);

        vecs.push_back(idle);
        vecs.push_back(mk(0, 1, 12'h010, 4'hF, 32'hDEADBEEF, 0, 0, 12'h0, 4'h0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 12'h000, 4'h0, 32'h0, 1, 0, 12'h010, 4'hF, 32'h0, 2));
        vecs.push_back(idle);
        vecs.push_back(mk(0, 1, 12'hFFF, 4'hF, 32'hFFFFFFFF, 0, 0, 12'h0, 4'h0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 12'hFFF, 4'h3, 32'h12345678, 0, 0, 12'h0, 4'h0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 12'h000, 4'h0, 32'h0, 1, 0, 12'hFFF, 4'hF, 32'h0, 2));
        vecs.push_back(mk(1, 0, 12'h010, 4'hF, 32'h0, 0, 0, 12'h0, 4'h0, 32'h0, 1));
`ifdef RAM_ARB_BURST_EN
        for (int i = 0; i < 10; i++) begin
            tie.gnt = (i % 5 == 4) ? 1 : 2;
            vecs.push_back(tie);
        end
        vecs.push_back(mk(0, 1, 12'h010, 4'hF, 32'hCAFEF00D, 1, 0, 12'h010, 4'hF, 32'h0, 2));
        vecs.push_back(mk(0, 1, 12'h010, 4'hF, 32'hCAFEF00D, 1, 0, 12'h010, 4'hF, 32'h0, 2));
        vecs.push_back(mk(0, 1, 12'h010, 4'hF, 32'hCAFEF00D, 0, 0, 12'h0, 4'h0, 32'h0, 1));
`else
        for (int i = 0; i < 8; i++) begin
            tie.gnt = (i % 2 == 0) ? 2 : 1;
            vecs.push_back(tie);
        end
        vecs.push_back(mk(0, 1, 12'h010, 4'hF, 32'hCAFEF00D, 1, 0, 12'h010, 4'hF, 32'h0, 2));
        vecs.push_back(mk(0, 1, 12'h010, 4'hF, 32'hCAFEF00D, 1, 0, 12'h010, 4'hF, 32'h0, 1));
`endif
        vecs.push_back(mk(0, 0, 12'h000, 4'h0, 32'h0, 1, 0, 12'h010, 4'hF, 32'h0, 2));
        vecs.push_back(idle);
        vecs.push_back(idle);

        foreach (vecs[i]) step(vecs[i]);

        // B read granted, then reset before its data returns: the valid must be dropped.
        step(mk(0, 0, 12'h000, 4'h0, 32'h0, 1, 0, 12'h010, 4'hF, 32'h0, 2));
        #1;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("midrd ram_chipselect", {31'b0, ram_chipselect}, 32'd0);
        @(posedge clk);
        #2;
        check("midrd b_readdatavalid", {31'b0, b_if.readdatavalid}, 32'd0);
        check("midrd a_readdatavalid", {31'b0, a_if.readdatavalid}, 32'd0);
        apply(idle);
        addr_known = 1'b0;
        reset_n = 1'b1;
        step(idle);
        step(idle);
        // last_gnt back to A, so B takes the first tie.
        tie.gnt = 2;
        step(tie);
        step(mk(1, 0, 12'h010, 4'hF, 32'h0, 0, 0, 12'h0, 4'h0, 32'h0, 1));
        step(idle);
        step(idle);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
